// File: rtl/fifo1k9_ctrl_pkg.sv
// Shared constants and flag helper for the 1024x9 FIFO controller.
// All port widths of the controller derive from the constants here.
package fifo1k9_ctrl_pkg;

  localparam int unsigned FIFO_DEPTH = 1024;
  localparam int unsigned FIFO_AW    = 10;
  localparam int unsigned FIFO_DW    = 9;
  localparam int unsigned FIFO_CW    = 11;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } flags_t;

  localparam flags_t RST_FLAGS = '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};

  function automatic flags_t calc_flags(input logic [FIFO_CW-1:0] cnt,
                                        input logic [FIFO_CW-1:0] af_lvl,
                                        input logic [FIFO_CW-1:0] ae_lvl);
    flags_t f;
    f.full         = (cnt == FIFO_CW'(FIFO_DEPTH));
    f.empty        = (cnt == '0);
    f.almost_full  = (cnt >= af_lvl);
    f.almost_empty = (cnt <= ae_lvl);
    return f;
  endfunction

endpackage

// File: rtl/fifo1k9_ctrl.sv
// Pointer/occupancy controller for an external 1024x9 dual-port RAM
// (port A write-only, port B read-only with a 1-cycle registered read).
module fifo1k9_ctrl
  import fifo1k9_ctrl_pkg::*;
#(
  parameter int unsigned AFULL_LVL  = 1008,
  parameter int unsigned AEMPTY_LVL = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [FIFO_DW-1:0] wr_data,
  input  logic               rd_en,
  output logic [FIFO_DW-1:0] rd_data,
  output logic               rd_valid,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [FIFO_CW-1:0] count,
  output logic               overflow,
  output logic               underflow,
  output logic [FIFO_AW-1:0] ram_addra,
  output logic [FIFO_DW-1:0] ram_dia,
  output logic               ram_cea,
  output logic               ram_wea,
  output logic [FIFO_AW-1:0] ram_addrb,
  output logic               ram_ceb,
  input  logic [FIFO_DW-1:0] ram_dob
);

  localparam logic [FIFO_CW-1:0] AF_LVL = FIFO_CW'(AFULL_LVL);
  localparam logic [FIFO_CW-1:0] AE_LVL = FIFO_CW'(AEMPTY_LVL);

  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_CW-1:0] count_q, count_d;
  flags_t             flags_q, flags_d;
  logic               rd_valid_q, rd_valid_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               push_ok, pop_ok;

  // Handshake: a push is taken when wr_en=1 and full=0, a pop when rd_en=1 and
  // empty=0, both only outside clr and reset; the RAM port strobes are exactly
  // these accept terms, and rd_valid follows an accepted pop by one cycle.
  always_comb begin
    push_ok = rst_n & ~clr & wr_en & ~flags_q.full;
    pop_ok  = rst_n & ~clr & rd_en & ~flags_q.empty;
  end

  always_comb begin
    wptr_d      = wptr_q + FIFO_AW'(push_ok);
    rptr_d      = rptr_q + FIFO_AW'(pop_ok);
    count_d     = count_q;
    rd_valid_d  = pop_ok;
    overflow_d  = ~clr & wr_en & flags_q.full;
    underflow_d = ~clr & rd_en & flags_q.empty;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + FIFO_CW'(1);
        2'b01:   count_d = count_q - FIFO_CW'(1);
        default: count_d = count_q;
      endcase
    end
    // Flags are derived from the next count so they move together with count.
    flags_d = calc_flags(count_d, AF_LVL, AE_LVL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      flags_q     <= RST_FLAGS;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      flags_q     <= flags_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    ram_cea      = push_ok;
    ram_wea      = push_ok;
    ram_addra    = wptr_q;
    ram_dia      = wr_data;
    ram_ceb      = pop_ok;
    ram_addrb    = rptr_q;
    rd_data      = ram_dob;
    rd_valid     = rd_valid_q;
    count        = count_q;
    full         = flags_q.full;
    empty        = flags_q.empty;
    almost_full  = flags_q.almost_full;
    almost_empty = flags_q.almost_empty;
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

endmodule

// File: doc/fifo1k9_ctrl.md
FIFO1K9_CTRL -- requirements
Module: fifo1k9_ctrl

Interface
REQ-001 The parameter AFULL_LVL (default 1008) SHALL set the occupancy at or above which almost_full asserts.
REQ-002 The parameter AEMPTY_LVL (default 16) SHALL set the occupancy at or below which almost_empty asserts.
REQ-003 The design SHALL use one clock and an asynchronous active-low reset.
REQ-004 clk  in  1  rising-edge clock for all logic and both RAM ports.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 clr  in  1  synchronous flush of all entries.
REQ-007 wr_en  in  1  push request.
REQ-008 wr_data  in  9  push data.
REQ-009 rd_en  in  1  pop request.
REQ-010 rd_data  out  9  popped data, valid while rd_valid=1.
REQ-011 rd_valid  out  1  one-cycle pulse, one cycle after an accepted pop.
REQ-012 full, empty, almost_full, almost_empty  out  1 each  occupancy flags.
REQ-013 count  out  11  current occupancy, 0..1024.
REQ-014 overflow, underflow  out  1 each  one-cycle pulses on a rejected push or pop.
REQ-015 ram_addra  out  10  RAM write address.
REQ-016 ram_dia  out  9  RAM write data.
REQ-017 ram_cea, ram_wea  out  1 each  RAM write port enable and write strobe.
REQ-018 ram_addrb  out  10  RAM read address.
REQ-019 ram_ceb  out  1  RAM read port enable.
REQ-020 ram_dob  in  9  RAM read data, registered inside the RAM, 1-cycle latency, NOREG.

Function
REQ-021 The block SHALL control an external 1024x9 true dual-port block RAM: port A is write-only, port B is read-only, and port-B web is tied low by the parent.
REQ-022 A push SHALL be accepted when wr_en=1 and full=0, driving ram_cea=ram_wea=1, ram_addra=wptr and ram_dia=wr_data combinationally in that same cycle; wptr SHALL then increment modulo 1024.
REQ-023 A pop SHALL be accepted when rd_en=1 and empty=0, driving ram_ceb=1 and ram_addrb=rptr in that cycle; rptr SHALL then increment modulo 1024.
REQ-024 When wr_en=0, ram_cea and ram_wea SHALL be 0; when rd_en=0, ram_ceb SHALL be 0; the address and data outputs are don't-care while their enable is 0.
REQ-025 rd_valid SHALL assert exactly one cycle after an accepted pop, with rd_data=ram_dob passed through unregistered.
REQ-026 count SHALL change as follows: +1 on a push only, -1 on a pop only, unchanged when both a push and a pop are accepted in the same cycle.
REQ-027 full=(count==1024), empty=(count==0), almost_full=(count>=AFULL_LVL), almost_empty=(count<=AEMPTY_LVL); all flags SHALL be registered and updated in the same cycle as count.
REQ-028 When full, a push SHALL be rejected with overflow pulsed, even if a pop is accepted in the same cycle.
REQ-029 When empty, a pop SHALL be rejected with underflow pulsed; a same-cycle push does not bypass to the read side.
REQ-030 Pointers SHALL wrap from 1023 to 0 with no gap, and each pointer SHALL increment by exactly 1 per accepted operation.
REQ-031 clr=1 SHALL zero wptr, rptr and count and suppress all pushes and pops that cycle; rd_valid from a pop in the previous cycle SHALL still be delivered; clr has priority over wr_en and rd_en.
REQ-032 A read and a write to the same RAM address in the same cycle cannot occur by construction; the design SHALL not depend on RAM collision behaviour.

Reset
REQ-033 While rst_n=0: wptr=0, rptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, overflow=0, underflow=0, ram_cea=0, ram_wea=0, ram_ceb=0.
REQ-034 Reset deassertion SHALL be synchronised to clk by the parent; the block SHALL accept a push on the first clk edge after rst_n rises.
REQ-035 A reset in mid-operation SHALL discard all contents and any in-flight pop, so that rd_valid does not assert after reset.

Structure
REQ-036 The shared package SHALL hold FIFO_DEPTH=1024, FIFO_AW=10, FIFO_DW=9 and FIFO_CW=11; the port widths SHALL derive from these constants.
REQ-037 The block SHALL have no sub-module; the RAM macro SHALL be instantiated by the parent alongside this block.

Verification
REQ-038 After reset, push 0x000..0x0FF then pop 256 times -> rd_data equals 0x000..0x0FF in order, each one cycle after its pop, and empty=1 at the end.
REQ-039 Push 1024 words -> full=1 and count=1024; a 1025th push -> overflow pulse, wptr unchanged; then push and pop in the same cycle -> push rejected, count=1023.
REQ-040 Pop on empty -> underflow pulse, no rd_valid, ram_ceb=0; push and pop together on empty -> count=1, no rd_valid.
REQ-041 Run 3000 cycles of random push/pop -> pointers wrap at least twice and data matches a scoreboard model; almost_full toggles at 1008 and almost_empty at 16.
REQ-042 Assert clr one cycle after a pop with count=500 -> rd_valid still pulses, then count=0 and empty=1; next push and pop return the new data.
REQ-043 Assert rst_n=0 with count=700 and a pop in flight -> all outputs take their REQ-033 values asynchronously and no rd_valid appears afterwards.
